branch_pc_unit: RTL and testbench

Program-counter and branch-resolution unit for the 16-bit datapath; it consumes the comparator's `BranchDecide` and turns it into the next fetch address. It holds the fetch PC, tracks the PC of the instruction in decode, and computes branch and jump targets. It kills the single wrong-path instruction fetched behind every taken redirect. It sits between instruction memory (driven by `PC`) and the decode stage (which supplies `IsBranch`, `IsJump`, `Imm`, `JumpAddr`).

---
 rtl/branch_pc_unit_pkg.sv | 15 +
 rtl/branch_target_adder.sv | 22 ++
 rtl/branch_pc_unit.sv | 96 +++++++++
 tb/tb_branch_pc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC unit: default widths, reset PC,
// instruction size and the decode-kill FSM state encoding.
package branch_pc_unit_pkg;

   localparam int unsigned DEFAULT_PC_W     = 16;
   localparam int unsigned DEFAULT_IMM_W    = 8;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
   localparam int unsigned INSN_BYTES       = 2;

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: PCD + instruction size + sign-extended Imm scaled to bytes.
module branch_target_adder
   import branch_pc_unit_pkg::*;
#(
   parameter int unsigned PC_W  = DEFAULT_PC_W,
   parameter int unsigned IMM_W = DEFAULT_IMM_W
) (
   input  logic [PC_W-1:0]  pcd,
   input  logic [IMM_W-1:0] imm,
   output logic [PC_W-1:0]  target
);

   logic [PC_W-1:0] imm_sext;
   logic [PC_W-1:0] offset;

   always_comb begin
      imm_sext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
      offset   = {imm_sext[PC_W-2:0], 1'b0};
      target   = pcd + PC_W'(INSN_BYTES) + offset;
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC, decode PC, branch/jump redirect and one-slot wrong-path kill.
// Optional taken/not-taken saturating counters under `BRANCH_STATS_EN.
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = DEFAULT_PC_W,
   parameter int unsigned     IMM_W    = DEFAULT_IMM_W,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             IsBranch,
   input  logic             BranchDecide,
   input  logic [IMM_W-1:0] Imm,
   input  logic             IsJump,
   input  logic [PC_W-1:0]  JumpAddr,
   output logic [PC_W-1:0]  PC,
   output logic [PC_W-1:0]  PCD,
   output logic             DValid,
   output logic             Redirect
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]      TakenCount,
   output logic [15:0]      NotTakenCount
`endif
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;
   logic            take_jump;
   logic            take_branch;

   branch_target_adder #(
      .PC_W  (PC_W),
      .IMM_W (IMM_W)
   ) u_target (
      .pcd    (PCD),
      .imm    (Imm),
      .target (target)
   );

   // Decode controls are only honoured for a live, unstalled instruction.
   always_comb begin
      DValid      = (state_q == RUN);
      take_jump   = DValid & ~Stall & IsJump;
      take_branch = DValid & ~Stall & ~IsJump & IsBranch & BranchDecide;
      Redirect    = take_jump | take_branch;

      state_d = state_q;
      if (!Stall) begin
         state_d = Redirect ? FLUSH : RUN;
      end

      pc_next = PC + PC_W'(INSN_BYTES);
      if (take_jump) begin
         pc_next = JumpAddr;
      end else if (take_branch) begin
         pc_next = target;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         PC      <= RESET_PC;
         PCD     <= RESET_PC;
         state_q <= FLUSH;
      end else if (!Stall) begin
         PC      <= pc_next;
         PCD     <= PC;
         state_q <= state_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic branch_resolved;

   assign branch_resolved = DValid & ~Stall & IsBranch & ~IsJump;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         TakenCount    <= '0;
         NotTakenCount <= '0;
      end else begin
         if (branch_resolved && BranchDecide && (TakenCount != '1)) begin
            TakenCount <= TakenCount + 16'd1;
         end
         if (branch_resolved && !BranchDecide && (NotTakenCount != '1)) begin
            NotTakenCount <= NotTakenCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit; counter checks compiled only with BRANCH_STATS_EN.
module tb_branch_pc_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        IsBranch;
   logic        BranchDecide;
   logic [7:0]  Imm;
   logic        IsJump;
   logic [15:0] JumpAddr;
   logic [15:0] PC;
   logic [15:0] PCD;
   logic        DValid;
   logic        Redirect;
`ifdef BRANCH_STATS_EN
   logic [15:0] TakenCount;
   logic [15:0] NotTakenCount;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 CLK = ~CLK;

   branch_pc_unit #(
      .PC_W     (16),
      .IMM_W    (8),
      .RESET_PC (16'h0000)
   ) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .Stall        (Stall),
      .IsBranch     (IsBranch),
      .BranchDecide (BranchDecide),
      .Imm          (Imm),
      .IsJump       (IsJump),
      .JumpAddr     (JumpAddr),
      .PC           (PC),
      .PCD          (PCD),
      .DValid       (DValid),
      .Redirect     (Redirect)
`ifdef BRANCH_STATS_EN
      ,
      .TakenCount   (TakenCount),
      .NotTakenCount(NotTakenCount)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      Stall = 0; IsBranch = 0; BranchDecide = 0; Imm = '0; IsJump = 0; JumpAddr = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      Reset = 0;
      #2 Reset = 1;
      #1;
      check("rst_pc", PC, 16'h0000);
      check("rst_pcd", PCD, 16'h0000);
      check("rst_dvalid", DValid, 0);
`ifdef BRANCH_STATS_EN
      check("rst_taken", TakenCount, 0);
      check("rst_ntaken", NotTakenCount, 0);
`endif
      @(negedge CLK);
      Reset = 0;
      #1;
      check("c0_pc", PC, 16'h0000);
      check("c0_dvalid", DValid, 0);
      check("c0_redirect", Redirect, 0);
      tick();
      check("c1_pc", PC, 16'h0002);
      check("c1_pcd", PCD, 16'h0000);
      check("c1_dvalid", DValid, 1);
      tick();
      check("c2_pc", PC, 16'h0004);
      check("c2_pcd", PCD, 16'h0002);
      tick();
      check("c3_pc", PC, 16'h0006);
      check("c3_pcd", PCD, 16'h0004);
      check("c3_dvalid", DValid, 1);

      // backward branch from PCD=0x0004 by -4 insns wraps to 0xFFFE
      IsBranch = 1; BranchDecide = 1; Imm = 8'hFC;
      #1;
      check("bwd_redirect", Redirect, 1);
      tick();
      check("bwd_pc", PC, 16'hFFFE);
      check("bwd_pcd", PCD, 16'h0006);
      check("bwd_dvalid", DValid, 0);
      #1;
      check("flush_ignore_redirect", Redirect, 0);
      tick();
      check("bwd_wrap_seq_pc", PC, 16'h0000);
      check("bwd_wrap_pcd", PCD, 16'hFFFE);
      check("bwd_after_dvalid", DValid, 1);
`ifdef BRANCH_STATS_EN
      check("bwd_taken", TakenCount, 1);
`endif
      idle();

      IsJump = 1; JumpAddr = 16'h0010;
      #1;
      check("j10_redirect", Redirect, 1);
      tick();
      check("j10_pc", PC, 16'h0010);
      check("j10_dvalid", DValid, 0);
      idle();
      tick();
      check("j10_pcd", PCD, 16'h0010);
      check("j10_dvalid2", DValid, 1);

      // taken beq at 0x0010, Imm=3 -> 0x0012 + 6
      IsBranch = 1; BranchDecide = 1; Imm = 8'h03;
      #1;
      check("beq_redirect", Redirect, 1);
      tick();
      check("beq_pc", PC, 16'h0018);
      check("beq_dvalid", DValid, 0);
      idle();
      tick();
      check("beq_seq_pc", PC, 16'h001A);
      check("beq_pcd", PCD, 16'h0018);
      check("beq_dvalid_back", DValid, 1);
`ifdef BRANCH_STATS_EN
      check("beq_taken", TakenCount, 2);
`endif

      IsJump = 1; JumpAddr = 16'h0020;
      tick();
      idle();
      tick();
      check("j20_pcd", PCD, 16'h0020);
      check("j20_pc", PC, 16'h0022);

      IsBranch = 1; BranchDecide = 0; Imm = 8'h05;
      #1;
      check("bne_nt_redirect", Redirect, 0);
      tick();
      check("bne_nt_pc", PC, 16'h0024);
      check("bne_nt_dvalid", DValid, 1);
`ifdef BRANCH_STATS_EN
      check("bne_nt_count", NotTakenCount, 1);
      check("bne_taken_same", TakenCount, 2);
`endif
      idle();

      // taken branch at PCD=0x0022 held behind a 3-cycle stall; target 0x0044
      IsBranch = 1; BranchDecide = 1; Imm = 8'h10; Stall = 1;
      #1;
      check("stall_redirect", Redirect, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", PC, 16'h0024);
         check("stall_pcd", PCD, 16'h0022);
         check("stall_redirect_hold", Redirect, 0);
      end
`ifdef BRANCH_STATS_EN
      check("stall_taken_frozen", TakenCount, 2);
`endif
      Stall = 0;
      #1;
      check("release_redirect", Redirect, 1);
      tick();
      check("release_pc", PC, 16'h0044);
      check("release_dvalid", DValid, 0);
      check("release_no_second", Redirect, 0);
      idle();
      tick();
      check("release_seq_pc", PC, 16'h0046);
`ifdef BRANCH_STATS_EN
      check("release_taken_once", TakenCount, 3);
`endif

      IsJump = 1; IsBranch = 1; BranchDecide = 1; Imm = 8'h03; JumpAddr = 16'h1234;
      #1;
      check("jb_redirect", Redirect, 1);
      tick();
      check("jb_pc", PC, 16'h1234);
      check("jb_dvalid", DValid, 0);
`ifdef BRANCH_STATS_EN
      check("jb_taken", TakenCount, 3);
      check("jb_ntaken", NotTakenCount, 1);
`endif
      idle();

      #1 Reset = 1;
      #1;
      check("midrst_pc", PC, 16'h0000);
      check("midrst_pcd", PCD, 16'h0000);
      check("midrst_dvalid", DValid, 0);
`ifdef BRANCH_STATS_EN
      check("midrst_taken", TakenCount, 0);
      check("midrst_ntaken", NotTakenCount, 0);
`endif
      @(negedge CLK);
      Reset = 0;
      tick();
      check("post_rst_pc", PC, 16'h0002);
      check("post_rst_dvalid", DValid, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
